mem_port_arbiter: RTL and testbench

Sequencer and arbiter sharing one single-port, fixed-latency unified memory between the CPU instruction-fetch stage and the data-memory stage. Accepts level requests from both, grants one at a time, issues the access, waits the memory latency, and returns a one-cycle ready pulse with captured read data. Data accesses have priority. A starvation counter guarantees fetch progress. Sits between the pipeline's fetch/memory stages and the memory macro; pipeline stall logic uses the ready pulses.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_arb_latency_counter.sv | 32 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, grant owner,
// and a saturating increment used by the fetch starvation counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    function automatic int sat_inc(input int value, input int limit);
        if (value >= limit) begin
            return limit;
        end else begin
            return value + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_latency_counter.sv
// Down-counter timing the fixed memory latency; done marks the cycle in which
// the memory read data is valid.
module arb_latency_counter #(
    parameter int LATENCY = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = $clog2(LATENCY + 1);

    logic [CW-1:0] count_r;

    // Load on issue, count down while waiting, park at zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= CW'(LATENCY);
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and the
// data stage: data wins arbitration unless fetch has been starved STARVE_LIMIT times.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t            state_r, next_state_s;
    grant_t            grant_r, grant_s;
    logic              we_r;
    logic [SW-1:0]     starve_r, starve_s;
    logic              arb_s, starved_s, wait_done_s, capture_s;
    logic              if_ready_s, dm_ready_s, mem_en_s, mem_we_s, busy_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s, if_rdata_s, dm_rdata_s;

    assign arb_s     = (state_r == ST_IDLE) && (if_req || dm_req);
    assign starved_s = (starve_r == SW'(STARVE_LIMIT));

    arb_latency_counter #(.LATENCY(MEM_LATENCY)) u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .load  (state_r == ST_ISSUE),
        .dec   (state_r == ST_WAIT),
        .done  (wait_done_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_s) next_state_s = ST_ISSUE;
                else       next_state_s = ST_IDLE;
            end
            ST_ISSUE: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_done_s) next_state_s = ST_RESP;
                else             next_state_s = ST_WAIT;
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Arbitration: data first, fetch when it is the only requester or is starved.
    always_comb begin
        grant_s  = grant_r;
        starve_s = starve_r;
        if (arb_s) begin
            if (if_req && (!dm_req || starved_s)) begin
                grant_s  = GRANT_FETCH;
                starve_s = '0;
            end else begin
                grant_s = GRANT_DATA;
                if (if_req) starve_s = SW'(sat_inc(int'(starve_r), STARVE_LIMIT));
                else        starve_s = '0;
            end
        end else begin
            grant_s  = grant_r;
            starve_s = starve_r;
        end
    end

    // Grant, write flag and starvation count are latched only at arbitration.
    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_r  <= GRANT_FETCH;
            we_r     <= 1'b0;
            starve_r <= '0;
        end else begin
            grant_r  <= grant_s;
            we_r     <= arb_s ? ((grant_s == GRANT_DATA) && dm_we) : we_r;
            starve_r <= starve_s;
        end
    end

    // Output next-values; the access strobe is issued from the arbitration cycle.
    always_comb begin
        mem_en_s  = arb_s;
        mem_we_s  = arb_s && (grant_s == GRANT_DATA) && dm_we;
        capture_s = (state_r == ST_WAIT) && wait_done_s;
        if (arb_s) begin
            mem_addr_s  = (grant_s == GRANT_DATA) ? dm_addr : if_addr;
            mem_wdata_s = (grant_s == GRANT_DATA) ? dm_wdata : mem_wdata;
        end else begin
            mem_addr_s  = mem_addr;
            mem_wdata_s = mem_wdata;
        end
        if_rdata_s = if_rdata;
        dm_rdata_s = dm_rdata;
        if (capture_s && (grant_r == GRANT_FETCH)) begin
            if_rdata_s = mem_rdata;
        end else if (capture_s && !we_r) begin
            dm_rdata_s = mem_rdata;
        end else begin
            if_rdata_s = if_rdata;
            dm_rdata_s = dm_rdata;
        end
        if_ready_s = (next_state_s == ST_RESP) && (grant_r == GRANT_FETCH);
        dm_ready_s = (next_state_s == ST_RESP) && (grant_r == GRANT_DATA);
        busy_s     = (next_state_s != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_ready  <= if_ready_s;
            dm_ready  <= dm_ready_s;
            if_rdata  <= if_rdata_s;
            dm_rdata  <= dm_rdata_s;
            mem_en    <= mem_en_s;
            mem_we    <= mem_we_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
            busy      <= busy_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table for single/contended/write
// accesses, then hand sequences for starvation, mid-access reset and latency spacing.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int LIM = 4;

    logic        clock;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        u1_if_ready, u1_dm_ready, u1_mem_en, u1_mem_we, u1_busy;
    logic [31:0] u1_if_rdata, u1_dm_rdata, u1_mem_addr, u1_mem_wdata;
    logic        u5_if_ready, u5_dm_ready, u5_mem_en, u5_mem_we, u5_busy;
    logic [31:0] u5_if_rdata, u5_dm_rdata, u5_mem_addr, u5_mem_wdata;
    logic        f_req;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int due      = -1;
    logic [31:0] pend;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIM)) u1 (
        .clock(clock), .reset(reset), .if_req(f_req), .if_addr(32'h60),
        .if_ready(u1_if_ready), .if_rdata(u1_if_rdata), .dm_req(1'b0), .dm_we(1'b0),
        .dm_addr(32'h0), .dm_wdata(32'h0), .dm_ready(u1_dm_ready), .dm_rdata(u1_dm_rdata),
        .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
        .mem_rdata(~u1_mem_addr), .busy(u1_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(5), .STARVE_LIMIT(LIM)) u5 (
        .clock(clock), .reset(reset), .if_req(f_req), .if_addr(32'h70),
        .if_ready(u5_if_ready), .if_rdata(u5_if_rdata), .dm_req(1'b0), .dm_we(1'b0),
        .dm_addr(32'h0), .dm_wdata(32'h0), .dm_ready(u5_dm_ready), .dm_rdata(u5_dm_rdata),
        .mem_en(u5_mem_en), .mem_we(u5_mem_we), .mem_addr(u5_mem_addr), .mem_wdata(u5_mem_wdata),
        .mem_rdata(~u5_mem_addr), .busy(u5_busy)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C010004;
        else             return a ^ 32'h5A5A0000;
    endfunction

    // Memory model: data is valid only in the cycle exactly LAT after mem_en.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            due  <= cyc + LAT;
            pend <= memfn(mem_addr);
        end
    end
    assign mem_rdata = (cyc == due) ? pend : 32'hBAD0BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [4:0]  ctl;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic [4:0] ctl, input logic [31:0] ea,
                                input logic [31:0] ed, input logic [31:0] ird,
                                input logic [31:0] drd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ctl = ctl; v.ea = ea; v.ed = ed; v.ird = ird; v.drd = drd;
        return v;
    endfunction

    vec_t tbl[23];
    logic g[6];
    int   t1[$];
    int   t5[$];

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({if_ready, dm_ready, mem_en, mem_we, busy}), 32'h0);
        check({tag, "_if_rdata"}, if_rdata, 32'h0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        logic [31:0] ir1, ir2, d1;
        int ng, budget, lat, rdy_seen;
        ir1 = 32'h8C010004;
        ir2 = 32'h5A5A0044;
        d1  = 32'h5A5A0100;
        // ctl = {mem_en, mem_we, if_ready, dm_ready, busy}
        tbl[0]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00000, 32'h0,   32'h0,        32'h0, 32'h0);
        tbl[1]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        5'b10001, 32'h40,  32'h0,        32'h0, 32'h0);
        tbl[2]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00001, 32'h0,   32'h0,        32'h0, 32'h0);
        tbl[3]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00001, 32'h0,   32'h0,        32'h0, 32'h0);
        tbl[4]  = mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00101, 32'h0,   32'h0,        ir1,   32'h0);
        tbl[5]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        5'b00000, 32'h0,   32'h0,        ir1,   32'h0);
        tbl[6]  = mk(1'b1, 32'h44,  1'b1, 1'b0, 32'h100, 32'h0,        5'b00000, 32'h0,   32'h0,        ir1,   32'h0);
        tbl[7]  = mk(1'b1, 32'h44,  1'b1, 1'b0, 32'h100, 32'h0,        5'b10001, 32'h100, 32'h0,        ir1,   32'h0);
        tbl[8]  = mk(1'b1, 32'h44,  1'b1, 1'b0, 32'h100, 32'h0,        5'b00001, 32'h0,   32'h0,        ir1,   32'h0);
        tbl[9]  = mk(1'b1, 32'h44,  1'b1, 1'b0, 32'h100, 32'h0,        5'b00001, 32'h0,   32'h0,        ir1,   32'h0);
        tbl[10] = mk(1'b1, 32'h44,  1'b1, 1'b0, 32'h100, 32'h0,        5'b00011, 32'h0,   32'h0,        ir1,   d1);
        tbl[11] = mk(1'b1, 32'h44,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00000, 32'h0,   32'h0,        ir1,   d1);
        tbl[12] = mk(1'b1, 32'h44,  1'b0, 1'b0, 32'h0,   32'h0,        5'b10001, 32'h44,  32'h0,        ir1,   d1);
        tbl[13] = mk(1'b1, 32'h44,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00001, 32'h0,   32'h0,        ir1,   d1);
        tbl[14] = mk(1'b1, 32'h44,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00001, 32'h0,   32'h0,        ir1,   d1);
        tbl[15] = mk(1'b1, 32'h44,  1'b0, 1'b0, 32'h0,   32'h0,        5'b00101, 32'h0,   32'h0,        ir2,   d1);
        tbl[16] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        5'b00000, 32'h0,   32'h0,        ir2,   d1);
        tbl[17] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 5'b00000, 32'h0,   32'h0,        ir2,   d1);
        tbl[18] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 5'b11001, 32'h200, 32'hDEADBEEF, ir2,   d1);
        tbl[19] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 5'b00001, 32'h0,   32'h0,        ir2,   d1);
        tbl[20] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 5'b00001, 32'h0,   32'h0,        ir2,   d1);
        tbl[21] = mk(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 5'b00011, 32'h0,   32'h0,        ir2,   d1);
        tbl[22] = mk(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        5'b00000, 32'h0,   32'h0,        ir2,   d1);

        reset = 1'b0; f_req = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        f_req = 1'b1;

        for (int k = 0; k < 23; k++) begin
            @(negedge clock);
            check($sformatf("row%0d_ctl", k), 32'({mem_en, mem_we, if_ready, dm_ready, busy}),
                  32'(tbl[k].ctl));
            check($sformatf("row%0d_if_rdata", k), if_rdata, tbl[k].ird);
            check($sformatf("row%0d_dm_rdata", k), dm_rdata, tbl[k].drd);
            if (tbl[k].ctl[4]) check($sformatf("row%0d_mem_addr", k), mem_addr, tbl[k].ea);
            if (tbl[k].ctl[3]) check($sformatf("row%0d_mem_wdata", k), mem_wdata, tbl[k].ed);
            if_req = tbl[k].ir; if_addr = tbl[k].ia; dm_req = tbl[k].dr;
            dm_we = tbl[k].dw; dm_addr = tbl[k].da; dm_wdata = tbl[k].dd;
        end

        // Starvation: data held high, fetch held until served.
        if_addr = 32'h80; if_req = 1'b1;
        dm_addr = 32'h300; dm_we = 1'b0; dm_req = 1'b1;
        ng = 0; budget = 0;
        while (ng < 6 && budget < 80) begin
            @(negedge clock);
            budget++;
            if (if_ready) begin
                check("starve_if_rdata", if_rdata, 32'h5A5A0080);
                if_req = 1'b0;
            end
            if (mem_en) begin
                g[ng] = (mem_addr == 32'h80);
                ng++;
            end
        end
        check("starve_grant_count", ng, 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < ng) check($sformatf("starve_grant%0d_is_fetch", i), 32'(g[i]), 32'(i == 4));
        end
        budget = 0;
        while (!dm_ready && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        check("starve_last_dm_ready", 32'(dm_ready), 32'h1);
        dm_req = 1'b0;

        // Reset during WAIT abandons the access without a ready pulse.
        @(negedge clock);
        if_addr = 32'h90; if_req = 1'b1;
        @(negedge clock);
        check("rst_issue_mem_en", 32'(mem_en), 32'h1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        if_req = 1'b0;
        check_zero("midrst");
        reset = 1'b1;
        rdy_seen = 0;
        repeat (6) begin
            @(negedge clock);
            rdy_seen += int'(if_ready) + int'(dm_ready);
        end
        check("midrst_no_ready", rdy_seen, 32'd0);
        if_addr = 32'h40; if_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!if_ready && lat < 20);
        if_req = 1'b0;
        check("post_rst_latency", lat, 32'(LAT + 2));
        check("post_rst_if_rdata", if_rdata, 32'h8C010004);

        // Back-to-back fetch spacing for latency 1 and 5.
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (u1_if_ready) t1.push_back(cyc);
            if (u5_if_ready) t5.push_back(cyc);
            if (u1_if_ready && t1.size() == 1) check("lat1_if_rdata", u1_if_rdata, ~32'h60);
        end
        check("lat1_ready_count_ge3", 32'(t1.size() >= 3), 32'h1);
        check("lat5_ready_count_ge3", 32'(t5.size() >= 3), 32'h1);
        if (t1.size() >= 3) begin
            check("lat1_spacing_a", t1[1] - t1[0], 32'd4);
            check("lat1_spacing_b", t1[2] - t1[1], 32'd4);
        end
        if (t5.size() >= 3) begin
            check("lat5_spacing_a", t5[1] - t5[0], 32'd8);
            check("lat5_spacing_b", t5[2] - t5[1], 32'd8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
